seq_hit_window_counter: RTL and testbench
=========================================

Name: seq_hit_window_counter

Overview:
- Downstream consumer of the 111/000 sequence detector.
- Takes the detector's per-bit hit output and counts hits over fixed-length windows of enabled input bits.
- Publishes each window's count with a one-cycle valid pulse and keeps a saturating running total.
- Raises an alarm once ALARM_HOLD consecutive windows reach ALARM_TH hits; feeds status/interrupt logic.

Parameters:
- WIN_LEN, 16: enabled samples per window; legal range ≥2.
- CNT_W, 5: width of win_count; must be ≥ clog2(WIN_LEN+1).
- ALARM_TH, 4: hits per window that mark a window as "over"; legal range 1..WIN_LEN.
- ALARM_HOLD, 2: consecutive over windows required to assert alarm; legal range ≥1.
- TOT_W, 16: width of total_hits.

Ports:
- clk  input  1  rising-edge clock, shared with the detector.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  sample enable; high on cycles where the detector consumes a valid input bit.
- hit  input  1  detector output y, sampled only when en=1.
- clr  input  1  synchronous clear of all counters, FSM and outputs.
- win_count  output  CNT_W  hit count of the last completed window.
- win_valid  output  1  one-cycle pulse; win_count is updated on this cycle.
- alarm  output  1  level output; high while the alarm FSM is in ALARM.
- total_hits  output  TOT_W  saturating count of all sampled hits since reset/clr.

Behaviour:
- Reset (async, rst=1): win_count=0, win_valid=0, alarm=0, total_hits=0; internal bit_cnt=0, acc=0, streak=0, FSM=IDLE.
- Priority: rst > clr > en. With clr=1, every register goes to its reset value at the clock edge; a coincident en/hit sample is dropped.
- Sampling: on an edge with en=1, bit_cnt advances and acc += hit. Cycles with en=0 change nothing, whatever hit is.
- Window close: the enabled edge where bit_cnt==WIN_LEN-1.
  - win_count ← acc+hit.
  - win_valid=1 for exactly that following cycle.
  - acc←0, bit_cnt←0.
  - Latency: 1 clock from the last sample edge to visible win_count/win_valid.
- Back-to-back windows with en held high: win_valid pulses every WIN_LEN cycles and never stretches.
- Full window: WIN_LEN hits gives win_count=WIN_LEN. No wrap, guaranteed by the CNT_W rule.
- total_hits: +1 per sampled hit, holds at 2^TOT_W-1 with no wrap.
- Alarm FSM: evaluated only at window close, using over = (acc+hit ≥ ALARM_TH).
  - IDLE: over → streak=1. If ALARM_HOLD==1, go to ALARM; otherwise go to ARMING. Not over → stay in IDLE.
  - ARMING: over → streak+1. If it reaches ALARM_HOLD, go to ALARM; otherwise stay in ARMING. Not over → IDLE, streak=0.
  - ALARM: over → stay. Not over → IDLE, streak=0.
  - Unused encodings → IDLE.
- alarm is registered from the next-state value, so it changes on the same cycle as the win_valid that caused the change.
- Reset or clr mid-window discards the partial window; the next window needs a full WIN_LEN enabled samples.
- hit is combinational from the detector. It is sampled at the same edge that advances the detector state, so it reflects the current bit.

Decomposition:
- Package seq_hit_pkg:
  - alarm-state enum: IDLE=2'b00, ARMING=2'b01, ALARM=2'b10.
  - default parameter constants.
  - clog2 helper function.
- One sub-module, sat_counter (parameter W; ports clk, rst, clr, inc, q), used for total_hits.
- Window timer, accumulator and FSM stay in the top module.

Test Plan:
- Reset: rst=1 for 3 cycles mid-stream → all outputs 0 immediately, without waiting for a clock edge. Release, then 16 en cycles with hit on samples 3 and 7 → one win_valid pulse, win_count=2, alarm=0, total_hits=2.
- Gapped enable: 16 enabled samples spread over 40 cycles, hit=1 on 5 enabled and 10 disabled cycles → win_count=5, win_valid only after the 16th enabled sample.
- Full window: en=hit=1 for 16 cycles → win_count=16, total_hits=16. The following window with hit=0 gives win_count=0.
- Alarm sequence (TH=4, HOLD=2): window counts 5,4,3,5,2,6,6.
  - alarm rises on the 2nd win_valid.
  - alarm falls on the 3rd.
  - alarm stays 0 through the 4th and 5th.
  - alarm rises again on the 7th.
- Saturation: en=hit=1 for 70000 cycles → total_hits holds 65535 with no wrap; win_valid keeps pulsing every 16 cycles with win_count=16.
- clr mid-window: 10 samples with 6 hits, then clr together with en=hit=1 → that sample is ignored. Next win_valid comes after exactly 16 more samples, with win_count reflecting only those samples. total_hits, alarm and streak are cleared.

Source files
------------

// File: rtl/seq_hit_pkg.sv
// Shared types and defaults for the sequence-hit window counter.
// Holds the alarm-state encoding, default parameters and a constant clog2 helper.
package seq_hit_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StArming = 2'b01,
    StAlarm  = 2'b10
  } alarm_state_e;

  localparam int unsigned DefWinLen    = 16;
  localparam int unsigned DefCntW      = 5;
  localparam int unsigned DefAlarmTh   = 4;
  localparam int unsigned DefAlarmHold = 2;
  localparam int unsigned DefTotW      = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Synchronous clear takes priority over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/seq_hit_window_counter.sv
// Counts detector hits over fixed windows of enabled samples, publishes each window's count,
// keeps a saturating running total and raises an alarm after a streak of busy windows.
module seq_hit_window_counter
  import seq_hit_pkg::*;
#(
  parameter int unsigned WIN_LEN    = DefWinLen,
  parameter int unsigned CNT_W      = DefCntW,
  parameter int unsigned ALARM_TH   = DefAlarmTh,
  parameter int unsigned ALARM_HOLD = DefAlarmHold,
  parameter int unsigned TOT_W      = DefTotW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             hit,
  input  logic             clr,
  output logic [CNT_W-1:0] win_count,
  output logic             win_valid,
  output logic             alarm,
  output logic [TOT_W-1:0] total_hits
);

  localparam int unsigned BitW    = clog2(WIN_LEN);
  localparam int unsigned StreakW = clog2(ALARM_HOLD + 1);
  localparam logic [BitW-1:0] LastBit = BitW'(WIN_LEN - 1);

  logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   win_count_q, win_count_d;
  logic               win_valid_q, win_valid_d;
  logic               alarm_q, alarm_d;
  logic [StreakW-1:0] streak_q, streak_d;
  alarm_state_e       state_q, state_d;
  logic [CNT_W-1:0]   acc_sum;
  logic               over;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    acc_d       = acc_q;
    win_count_d = win_count_q;
    win_valid_d = 1'b0;
    streak_d    = streak_q;
    state_d     = state_q;
    acc_sum     = acc_q + CNT_W'(hit);
    over        = (acc_sum >= CNT_W'(ALARM_TH));

    if (clr) begin
      bit_cnt_d   = '0;
      acc_d       = '0;
      win_count_d = '0;
      streak_d    = '0;
      state_d     = StIdle;
    end else if (en) begin
      if (bit_cnt_q == LastBit) begin
        win_count_d = acc_sum;
        win_valid_d = 1'b1;
        acc_d       = '0;
        bit_cnt_d   = '0;
        // The alarm FSM only moves when a window closes.
        case (state_q)
          StIdle: begin
            if (over) begin
              streak_d = StreakW'(1);
              state_d  = (ALARM_HOLD == 1) ? StAlarm : StArming;
            end
          end
          StArming: begin
            if (over) begin
              streak_d = streak_q + StreakW'(1);
              if ((int'(streak_q) + 1) >= int'(ALARM_HOLD)) begin
                state_d = StAlarm;
              end
            end else begin
              streak_d = '0;
              state_d  = StIdle;
            end
          end
          StAlarm: begin
            if (!over) begin
              streak_d = '0;
              state_d  = StIdle;
            end
          end
          default: begin
            streak_d = '0;
            state_d  = StIdle;
          end
        endcase
      end else begin
        bit_cnt_d = bit_cnt_q + BitW'(1);
        acc_d     = acc_sum;
      end
    end

    // Registered from next state so alarm moves together with win_valid.
    alarm_d = (state_d == StAlarm);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      acc_q       <= '0;
      win_count_q <= '0;
      win_valid_q <= 1'b0;
      alarm_q     <= 1'b0;
      streak_q    <= '0;
      state_q     <= StIdle;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      acc_q       <= acc_d;
      win_count_q <= win_count_d;
      win_valid_q <= win_valid_d;
      alarm_q     <= alarm_d;
      streak_q    <= streak_d;
      state_q     <= state_d;
    end
  end

  sat_counter #(
    .W(TOT_W)
  ) u_total (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .inc(en & hit),
    .q  (total_hits)
  );

  assign win_count = win_count_q;
  assign win_valid = win_valid_q;
  assign alarm     = alarm_q;

endmodule

// File: tb/tb_seq_hit_window_counter.sv
// Randomized bench for seq_hit_window_counter against a window/run-length reference model.
module tb_seq_hit_window_counter;

  localparam int Win  = 16;
  localparam int Th   = 4;
  localparam int Hold = 2;
  localparam int TotMax = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        hit = 1'b0;
  logic        clr = 1'b0;
  logic [4:0]  win_count;
  logic        win_valid;
  logic        alarm;
  logic [15:0] total_hits;

  int tests = 0;
  int fails = 0;

  // Reference model: samples in current window, hits so far, last published window,
  // total, and length of the current run of over-threshold windows.
  int         m_bits, m_acc, m_total, m_run;
  logic [4:0] m_count;
  logic       m_valid, m_alarm;

  seq_hit_window_counter dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .hit       (hit),
    .clr       (clr),
    .win_count (win_count),
    .win_valid (win_valid),
    .alarm     (alarm),
    .total_hits(total_hits)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_bits = 0; m_acc = 0; m_total = 0; m_run = 0;
    m_count = '0; m_valid = 1'b0; m_alarm = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model at the edge, return at edge+1.
  task automatic drive(input logic e, input logic h, input logic c);
    en = e; hit = h; clr = c;
    @(posedge clk);
    m_valid = 1'b0;
    if (c) begin
      model_reset();
    end else if (e) begin
      if (h) begin
        m_acc++;
        if (m_total < TotMax) m_total++;
      end
      m_bits++;
      if (m_bits == Win) begin
        m_count = 5'(m_acc);
        m_valid = 1'b1;
        m_run   = (m_acc >= Th) ? ((m_run < Hold) ? m_run + 1 : Hold) : 0;
        m_alarm = (m_run >= Hold);
        m_acc   = 0;
        m_bits  = 0;
      end
    end
    #1;
  endtask

  function automatic logic [15:0] make_pattern(input int k);
    logic [15:0] p;
    int n;
    p = '0;
    n = 0;
    while (n < k) begin
      int b;
      b = int'($urandom_range(0, 15));
      if (!p[b]) begin
        p[b] = 1'b1;
        n++;
      end
    end
    return p;
  endfunction

  task automatic test_reset();
    int vcount;
    tests++;
    if (win_valid !== 1'b0 || alarm !== 1'b0 || win_count !== 5'd0 || total_hits !== 16'd0) begin
      fails++;
      $display("FAIL power_on_reset: got v=%0b c=%0d a=%0b t=%0d expected all 0",
               win_valid, win_count, alarm, total_hits);
    end
    for (int i = 0; i < 21; i++) drive(1'b1, (i % 3 == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (win_valid !== 1'b0 || alarm !== 1'b0 || win_count !== 5'd0 || total_hits !== 16'd0) begin
      fails++;
      $display("FAIL async_reset: got v=%0b c=%0d a=%0b t=%0d expected all 0 before edge",
               win_valid, win_count, alarm, total_hits);
    end
    en = 1'b1; hit = 1'b1;
    repeat (3) @(posedge clk);
    model_reset();
    #2 rst = 1'b0; en = 1'b0; hit = 1'b0;
    vcount = 0;
    for (int i = 0; i < Win; i++) begin
      drive(1'b1, (i == 2 || i == 6) ? 1'b1 : 1'b0, 1'b0);
      if (win_valid === 1'b1) vcount++;
      tests++;
      if ({win_valid, win_count, alarm, total_hits} !== {m_valid, m_count, m_alarm, 16'(m_total)}) begin
        fails++;
        $display("FAIL reset_window: got v=%0b c=%0d a=%0b t=%0d expected v=%0b c=%0d a=%0b t=%0d",
                 win_valid, win_count, alarm, total_hits, m_valid, m_count, m_alarm, m_total);
      end
    end
    tests++;
    if (vcount !== 1 || win_count !== 5'd2 || alarm !== 1'b0 || total_hits !== 16'd2) begin
      fails++;
      $display("FAIL reset_window_result: got pulses=%0d c=%0d a=%0b t=%0d expected 1 2 0 2",
               vcount, win_count, alarm, total_hits);
    end
    drive(1'b0, 1'b1, 1'b0);
    tests++;
    if (win_valid !== 1'b0 || total_hits !== 16'd2) begin
      fails++;
      $display("FAIL valid_one_cycle: got v=%0b t=%0d expected v=0 t=2", win_valid, total_hits);
    end
  endtask

  task automatic test_gapped_enable();
    int kind[40];
    int seen, vcount;
    logic e, h;
    for (int i = 0; i < 40; i++) kind[i] = i;
    for (int i = 39; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(0, i));
      t = kind[i]; kind[i] = kind[j]; kind[j] = t;
    end
    seen = 0;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      e = (kind[i] < 16);
      h = (kind[i] < 5) || (kind[i] >= 16 && kind[i] < 26);
      drive(e, h, 1'b0);
      if (e) seen++;
      if (win_valid === 1'b1) vcount++;
      tests++;
      if (win_valid !== ((e && seen == 16) ? 1'b1 : 1'b0)) begin
        fails++;
        $display("FAIL gapped_valid_timing: cycle %0d got v=%0b after %0d enabled samples",
                 i, win_valid, seen);
      end
      tests++;
      if ({win_valid, win_count, alarm, total_hits} !== {m_valid, m_count, m_alarm, 16'(m_total)}) begin
        fails++;
        $display("FAIL gapped: got v=%0b c=%0d a=%0b t=%0d expected v=%0b c=%0d a=%0b t=%0d",
                 win_valid, win_count, alarm, total_hits, m_valid, m_count, m_alarm, m_total);
      end
    end
    tests++;
    if (vcount !== 1 || win_count !== 5'd5) begin
      fails++;
      $display("FAIL gapped_result: got pulses=%0d c=%0d expected 1 5", vcount, win_count);
    end
  endtask

  task automatic test_full_window();
    int start_total;
    start_total = m_total;
    for (int i = 0; i < Win; i++) drive(1'b1, 1'b1, 1'b0);
    tests++;
    if (win_valid !== 1'b1 || win_count !== 5'd16 || total_hits !== 16'(start_total + 16)) begin
      fails++;
      $display("FAIL full_window: got v=%0b c=%0d t=%0d expected 1 16 %0d",
               win_valid, win_count, total_hits, start_total + 16);
    end
    for (int i = 0; i < Win; i++) drive(1'b1, 1'b0, 1'b0);
    tests++;
    if (win_valid !== 1'b1 || win_count !== 5'd0 || alarm !== m_alarm) begin
      fails++;
      $display("FAIL empty_window: got v=%0b c=%0d a=%0b expected 1 0 %0b",
               win_valid, win_count, alarm, m_alarm);
    end
  endtask

  task automatic test_alarm_sequence();
    int counts[7];
    logic exp_alarm[7];
    logic [15:0] pat;
    counts = '{5, 4, 3, 5, 2, 6, 6};
    exp_alarm = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    drive(1'b0, 1'b0, 1'b1);
    for (int w = 0; w < 7; w++) begin
      pat = make_pattern(counts[w]);
      for (int i = 0; i < Win; i++) begin
        drive(1'b1, pat[i], 1'b0);
        tests++;
        if ({win_valid, win_count, alarm, total_hits} !== {m_valid, m_count, m_alarm, 16'(m_total)}) begin
          fails++;
          $display("FAIL alarm_seq: got v=%0b c=%0d a=%0b t=%0d expected v=%0b c=%0d a=%0b t=%0d",
                   win_valid, win_count, alarm, total_hits, m_valid, m_count, m_alarm, m_total);
        end
      end
      tests++;
      if (win_valid !== 1'b1 || alarm !== exp_alarm[w] || win_count !== 5'(counts[w])) begin
        fails++;
        $display("FAIL alarm_window_%0d: got v=%0b a=%0b c=%0d expected v=1 a=%0b c=%0d",
                 w + 1, win_valid, alarm, win_count, exp_alarm[w], counts[w]);
      end
    end
  endtask

  task automatic test_saturation();
    int bad;
    bad = 0;
    for (int i = 0; i < 70000; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      tests++;
      if ({win_valid, win_count, alarm, total_hits} !== {m_valid, m_count, m_alarm, 16'(m_total)}) begin
        fails++;
        bad++;
        if (bad < 5) begin
          $display("FAIL saturation: cyc %0d got v=%0b c=%0d a=%0b t=%0d expected v=%0b c=%0d a=%0b t=%0d",
                   i, win_valid, win_count, alarm, total_hits, m_valid, m_count, m_alarm, m_total);
        end
      end
    end
    tests++;
    if (total_hits !== 16'hFFFF || win_count !== 5'd16) begin
      fails++;
      $display("FAIL saturation_end: got t=%0d c=%0d expected 65535 16", total_hits, win_count);
    end
  endtask

  task automatic test_clr_mid_window();
    logic [15:0] pat;
    int k, vcount;
    pat = make_pattern(6);
    for (int i = 0; i < 10; i++) drive(1'b1, (i < 6) ? 1'b1 : 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    tests++;
    if (total_hits !== 16'd0 || alarm !== 1'b0 || win_count !== 5'd0 || win_valid !== 1'b0) begin
      fails++;
      $display("FAIL clr_outputs: got t=%0d a=%0b c=%0d v=%0b expected all 0",
               total_hits, alarm, win_count, win_valid);
    end
    k = int'($urandom_range(4, 12));
    pat = make_pattern(k);
    vcount = 0;
    for (int i = 0; i < Win; i++) begin
      drive(1'b1, pat[i], 1'b0);
      if (win_valid === 1'b1) vcount++;
      tests++;
      if (win_valid !== ((i == Win - 1) ? 1'b1 : 1'b0)) begin
        fails++;
        $display("FAIL clr_window_timing: sample %0d got v=%0b", i, win_valid);
      end
    end
    tests++;
    if (vcount !== 1 || win_count !== 5'(k) || total_hits !== 16'(k) || alarm !== 1'b0) begin
      fails++;
      $display("FAIL clr_window_result: got pulses=%0d c=%0d t=%0d a=%0b expected 1 %0d %0d 0",
               vcount, win_count, total_hits, alarm, k, k);
    end
  endtask

  task automatic test_random();
    logic e, h, c;
    for (int i = 0; i < 600; i++) begin
      e = 1'($urandom_range(0, 3) != 0);
      h = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 99) == 0);
      drive(e, h, c);
      tests++;
      if ({win_valid, win_count, alarm, total_hits} !== {m_valid, m_count, m_alarm, 16'(m_total)}) begin
        fails++;
        $display("FAIL random: cyc %0d got v=%0b c=%0d a=%0b t=%0d expected v=%0b c=%0d a=%0b t=%0d",
                 i, win_valid, win_count, alarm, total_hits, m_valid, m_count, m_alarm, m_total);
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    test_reset();
    test_gapped_enable();
    test_full_window();
    test_alarm_sequence();
    test_saturation();
    test_clr_mid_window();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
